anita_phi_coinc_trigger: RTL and testbench

ANITA_PHI_COINC_TRIGGER -- requirements
Module: anita_phi_coinc_trigger

---
 rtl/anita_phi_coinc_trigger.sv | 147 ++++++++++++++
 tb/tb_anita_phi_coinc_trigger.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/anita_phi_coinc_trigger.sv
// Phi-sector coincidence trigger: windowed multiplicity seeds per polarisation,
// OR-combined, then gated by a holdoff FSM with issued/suppressed counters.

module anita_phi_seed_cell #(
  parameter int WINDOW = 2
) (
  input  logic [WINDOW-1:0] win,
  input  logic              mask,
  input  logic [2:0]        m_eff,
  input  logic              m_ok,
  output logic              seed
);
  logic [2:0] pop;

  always_comb begin
    pop = '0;
    for (int k = 0; k < WINDOW; k++) pop = pop + 3'(win[k]);
  end

  // win[0] is the seed sector itself; the rest are its clockwise neighbours
  assign seed = win[0] & ~mask & m_ok & (pop >= m_eff);
endmodule

module anita_phi_coinc_trigger #(
  parameter int NUM_PHI   = 16,
  parameter int WINDOW    = 2,
  parameter int HOLD_BITS = 8
) (
  input  logic                   clk250_i,
  input  logic                   rst_i,
  input  logic [NUM_PHI-1:0]     v_phi_i,
  input  logic [NUM_PHI-1:0]     h_phi_i,
  input  logic [2*NUM_PHI-1:0]   phi_mask_i,
  input  logic [2:0]             mult_i,
  input  logic [HOLD_BITS-1:0]   holdoff_i,
  input  logic                   disable_i,
  output logic                   trig_o,
  output logic [2*NUM_PHI-1:0]   phi_o,
  output logic [7:0]             count_o,
  output logic [7:0]             supp_count_o
);
  localparam int NCELL = 2*NUM_PHI;

  typedef enum logic {IDLE, HOLD} state_t;

  logic [NCELL-1:0]     hits;
  logic [NCELL-1:0]     seed_c;
  logic [NCELL-1:0]     seed_q;
  logic [NCELL-1:0]     phi_d1, phi_d2;
  logic [2:0]           m_eff;
  logic                 m_ok;
  logic                 any_trig, any_prev, dis_q;
  logic                 fire, rise;
  state_t               state, state_n;
  logic [HOLD_BITS-1:0] hold_cnt, cnt_n;

  assign hits  = {h_phi_i, v_phi_i};
  assign m_eff = (mult_i == 3'd0) ? 3'd1 : mult_i;
  assign m_ok  = (m_eff <= 3'(WINDOW));

  // V cells occupy [NUM_PHI-1:0], H cells the upper half; each window wraps
  // within its own polarisation.
  genvar j, k;
  generate
    for (j = 0; j < NCELL; j++) begin : g_cell
      localparam int POL = j / NUM_PHI;
      localparam int SEC = j % NUM_PHI;
      logic [WINDOW-1:0] win;
      for (k = 0; k < WINDOW; k++) begin : g_win
        assign win[k] = hits[POL*NUM_PHI + ((SEC + k) % NUM_PHI)];
      end
      anita_phi_seed_cell #(.WINDOW(WINDOW)) u_cell (
        .win  (win),
        .mask (phi_mask_i[j]),
        .m_eff(m_eff),
        .m_ok (m_ok),
        .seed (seed_c[j])
      );
    end
  endgenerate

  // stage 1 / stage 2
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      seed_q   <= '0;
      phi_d1   <= '0;
      phi_d2   <= '0;
      any_trig <= 1'b0;
      any_prev <= 1'b0;
      dis_q    <= 1'b0;
    end else begin
      seed_q   <= seed_c;
      phi_d1   <= hits;
      phi_d2   <= phi_d1;
      any_trig <= |seed_q;
      any_prev <= any_trig;
      dis_q    <= disable_i;
    end
  end

  assign rise = any_trig & ~any_prev;

  always_comb begin
    state_n = state;
    cnt_n   = hold_cnt;
    fire    = 1'b0;
    case (state)
      IDLE: begin
        if (any_trig && !dis_q) begin
          fire    = 1'b1;
          state_n = HOLD;
          cnt_n   = (holdoff_i == '0) ? HOLD_BITS'(1) : holdoff_i;
        end
      end
      HOLD: begin
        cnt_n = hold_cnt - HOLD_BITS'(1);
        // leaving on the edge the counter hits 0 gives holdoff+1 spacing
        if (hold_cnt <= HOLD_BITS'(1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // stage 3
  always_ff @(posedge clk250_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      trig_o       <= 1'b0;
      phi_o        <= '0;
      count_o      <= '0;
      supp_count_o <= '0;
    end else begin
      state    <= state_n;
      hold_cnt <= cnt_n;
      trig_o   <= fire;
      if (fire) begin
        phi_o   <= phi_d2;
        count_o <= count_o + 8'd1;
      end
      if (rise && !fire) supp_count_o <= supp_count_o + 8'd1;
    end
  end
endmodule

// File: tb/tb_anita_phi_coinc_trigger.sv
// Directed bench for anita_phi_coinc_trigger with hand-derived expectations.

module tb_anita_phi_coinc_trigger;
  localparam int NUM_PHI = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [15:0]  v_phi, h_phi;
  logic [31:0]  phi_mask;
  logic [2:0]   mult;
  logic [7:0]   holdoff;
  logic         dis;
  logic         trig;
  logic [31:0]  phi;
  logic [7:0]   count, supp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int trig_q[$];

  anita_phi_coinc_trigger #(.NUM_PHI(NUM_PHI), .WINDOW(2), .HOLD_BITS(8)) dut (
    .clk250_i    (clk),
    .rst_i       (rst),
    .v_phi_i     (v_phi),
    .h_phi_i     (h_phi),
    .phi_mask_i  (phi_mask),
    .mult_i      (mult),
    .holdoff_i   (holdoff),
    .disable_i   (dis),
    .trig_o      (trig),
    .phi_o       (phi),
    .count_o     (count),
    .supp_count_o(supp)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (trig) trig_q.push_back(cyc);

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_v(input logic [15:0] b);
    v_phi = b; tick(1); v_phi = '0;
  endtask

  task automatic pulse_h(input logic [15:0] b);
    h_phi = b; tick(1); h_phi = '0;
  endtask

  initial begin
    rst = 1'b1; v_phi = '0; h_phi = '0; phi_mask = '0;
    mult = 3'd2; holdoff = 8'd10; dis = 1'b0;
    tick(3);
    chk("rst_trig", 32'(trig), 0);
    chk("rst_phi", phi, 0);
    chk("rst_cnt", 32'(count), 0);
    chk("rst_supp", 32'(supp), 0);
    rst = 1'b0;
    tick(2);

    // adjacent pair 3,4: latency 3
    pulse_v(16'h0018);
    tick(1); chk("lat_n2", 32'(trig), 0);
    tick(1); chk("lat_n3", 32'(trig), 1);
    chk("pair_phi", phi, 32'h0000_0018);
    chk("pair_cnt", 32'(count), 1);
    tick(1); chk("one_cycle", 32'(trig), 0);
    tick(12);

    // non-adjacent pair: no coincidence
    pulse_v(16'h0028); tick(5);
    chk("nonadj_cnt", 32'(count), 1);
    chk("nonadj_supp", 32'(supp), 0);

    // wrap-around pair 15,0 in H
    pulse_h(16'h8001); tick(2);
    chk("wrap_trig", 32'(trig), 1);
    chk("wrap_phi", phi, 32'h8001_0000);
    tick(12);
    phi_mask = 32'h8000_0000;
    pulse_h(16'h8001); tick(5);
    chk("mask_cnt", 32'(count), 2);
    chk("mask_phi_hold", phi, 32'h8001_0000);
    phi_mask = '0;

    // mult 0 behaves as 1
    mult = 3'd0;
    pulse_v(16'h0100); tick(2);
    chk("m0_trig", 32'(trig), 1);
    chk("m0_phi", phi, 32'h0000_0100);
    tick(12);
    mult = 3'd2;

    // second pulse 4 cycles later lands in HOLD
    trig_q.delete();
    pulse_v(16'h0018); tick(3); pulse_v(16'h0018); tick(20);
    chk("hold4_ntrig", 32'(trig_q.size()), 1);
    chk("hold4_supp", 32'(supp), 1);
    chk("hold4_cnt", 32'(count), 4);

    // rise in the HOLD->IDLE cycle is suppressed
    trig_q.delete();
    pulse_v(16'h0018); tick(9); pulse_v(16'h0018); tick(20);
    chk("edge_ntrig", 32'(trig_q.size()), 1);
    chk("edge_supp", 32'(supp), 2);

    // one cycle later it fires: spacing holdoff+1
    trig_q.delete();
    pulse_v(16'h0018); tick(10); pulse_v(16'h0018); tick(20);
    chk("space_ntrig", 32'(trig_q.size()), 2);
    if (trig_q.size() == 2) chk("space_gap", 32'(trig_q[1] - trig_q[0]), 11);
    chk("space_supp", 32'(supp), 2);

    // continuous hit: reissue every 11 cycles, no suppression
    trig_q.delete();
    v_phi = 16'h0018; tick(25); v_phi = '0; tick(20);
    chk("cont_ntrig", 32'(trig_q.size()), 3);
    if (trig_q.size() == 3) begin
      chk("cont_gap0", 32'(trig_q[1] - trig_q[0]), 11);
      chk("cont_gap1", 32'(trig_q[2] - trig_q[1]), 11);
    end
    chk("cont_cnt", 32'(count), 10);
    chk("cont_supp", 32'(supp), 2);

    // disable: suppressed, FSM stays IDLE
    trig_q.delete();
    dis = 1'b1; tick(2);
    pulse_v(16'h0018); tick(3);
    dis = 1'b0; tick(1);
    chk("dis_ntrig", 32'(trig_q.size()), 0);
    chk("dis_supp", 32'(supp), 3);
    pulse_v(16'h0018);
    tick(1); chk("dis_after_n2", 32'(trig), 0);
    tick(1); chk("dis_after_trig", 32'(trig), 1);
    chk("dis_after_cnt", 32'(count), 11);
    tick(15);

    // multiplicity above the window: never triggers
    mult = 3'd5;
    v_phi = '1; h_phi = '1; tick(1); v_phi = '0; h_phi = '0; tick(5);
    mult = 3'd3;
    v_phi = '1; h_phi = '1; tick(1); v_phi = '0; h_phi = '0; tick(5);
    chk("mhigh_cnt", 32'(count), 11);
    chk("mhigh_supp", 32'(supp), 3);
    mult = 3'd2;

    // reset 3 cycles into HOLD
    pulse_v(16'h0018); tick(2);
    chk("pre_rst_trig", 32'(trig), 1);
    tick(3);
    rst = 1'b1; #1;
    chk("midrst_cnt", 32'(count), 0);
    chk("midrst_phi", phi, 0);
    chk("midrst_supp", 32'(supp), 0);
    tick(2);
    rst = 1'b0;
    pulse_v(16'h0018); tick(1);
    chk("post_rst_n2", 32'(trig), 0);
    tick(1);
    chk("post_rst_trig", 32'(trig), 1);
    chk("post_rst_cnt", 32'(count), 1);
    tick(15);

    // counter wrap after 256 triggers
    rst = 1'b1; tick(1); rst = 1'b0; holdoff = 8'd1; tick(2);
    trig_q.delete();
    repeat (255) begin pulse_v(16'h0018); tick(3); end
    tick(5);
    chk("cnt_255", 32'(count), 255);
    pulse_v(16'h0018); tick(5);
    chk("wrap_ntrig", 32'(trig_q.size()), 256);
    chk("cnt_wrap", 32'(count), 0);
    chk("wrap_supp", 32'(supp), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
